// File: rtl/sr_4094_ctrl_pkg.sv
// Shared FSM state encodings and default chain geometry for the 4094 serialiser.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package sr_4094_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_LATCH    = 3'd3,
    ST_DONE     = 3'd4
  } sr_state_t;

  // Four 4094s in the chain, sr_clk half period of 4 clk cycles.
  localparam int SR_WIDTH_DEF = 32;
  localparam int SR_DIV_DEF   = 4;

endpackage

// File: rtl/sr_div_tick.sv
// Loadable down-counter pacing each FSM phase; tick marks the last cycle of a phase.
// Latency: tick asserts DIV-1 cycles after a load (immediately when DIV=1).
// Backpressure: none; load has priority and restarts the count.
module sr_div_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(DIV - 1);

  logic [7:0] cnt;

  assign tick = (cnt == 8'd0);

  // Reload on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

endmodule

// File: rtl/sr_4094_ctrl.sv
// Shifts a WIDTH-bit word MSB first into a 4094 chain, strobes it, and gates OE once loaded.
// Latency: done pulses 2*DIV*WIDTH + DIV + 1 cycles after start; queued transfers follow back to back.
// Backpressure: start is never dropped; one transfer queues while busy, latest data wins.
module sr_4094_ctrl
  import sr_4094_ctrl_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH_DEF,
  parameter int DIV   = SR_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic             oe_en,
  output logic             busy,
  output logic             done,
  output logic             sr_clk,
  output logic             sr_data,
  output logic             sr_strobe,
  output logic             sr_oe
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sr_state_t        state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [WIDTH-1:0] pend_dat;
  logic [WIDTH-1:0] launch_dat;
  logic             pending;
  logic             loaded;
  logic [CW-1:0]    bitcnt;
  logic             div_load;
  logic             tick;

  // The divider is held at its reload value in the single-cycle states so every
  // timed phase starts with a full DIV count.
  assign div_load   = (state == ST_IDLE) || (state == ST_DONE) || tick;
  assign shreg_nxt  = {shreg[WIDTH-2:0], 1'b0};
  // A start arriving in the DONE cycle is newer than anything buffered.
  assign launch_dat = start ? data : pend_dat;

  sr_div_tick #(.DIV(DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .load  (div_load),
    .tick  (tick)
  );

  // Transfer FSM with all pin-facing outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      pend_dat  <= '0;
      pending   <= 1'b0;
      loaded    <= 1'b0;
      bitcnt    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sr_clk    <= 1'b0;
      sr_data   <= 1'b0;
      sr_strobe <= 1'b0;
      sr_oe     <= 1'b0;
    end else begin
      done  <= 1'b0;
      sr_oe <= loaded & oe_en;

      // Capture a request that arrives mid-transfer; DONE consumes start directly.
      if (start && (state != ST_IDLE) && (state != ST_DONE)) begin
        pending  <= 1'b1;
        pend_dat <= data;
      end

      case (state)
        ST_IDLE: begin
          sr_clk    <= 1'b0;
          sr_data   <= 1'b0;
          sr_strobe <= 1'b0;
          if (start) begin
            shreg   <= data;
            bitcnt  <= CW'(WIDTH - 1);
            sr_data <= data[WIDTH-1];
            busy    <= 1'b1;
            state   <= ST_SHIFT_LO;
          end
        end

        ST_SHIFT_LO: begin
          if (tick) begin
            sr_clk <= 1'b1;
            state  <= ST_SHIFT_HI;
          end
        end

        ST_SHIFT_HI: begin
          if (tick) begin
            shreg  <= shreg_nxt;
            sr_clk <= 1'b0;
            if (bitcnt == '0) begin
              sr_data   <= 1'b0;
              sr_strobe <= 1'b1;
              state     <= ST_LATCH;
            end else begin
              bitcnt  <= bitcnt - CW'(1);
              sr_data <= shreg_nxt[WIDTH-1];
              state   <= ST_SHIFT_LO;
            end
          end
        end

        ST_LATCH: begin
          if (tick) begin
            sr_strobe <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            loaded    <= 1'b1;
            state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (start || pending) begin
            shreg   <= launch_dat;
            bitcnt  <= CW'(WIDTH - 1);
            sr_data <= launch_dat[WIDTH-1];
            pending <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_SHIFT_LO;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_4094_ctrl.sv
// Directed bench for sr_4094_ctrl: 8-bit/DIV=2 instance plus a 32-bit/DIV=1 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_sr_4094_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        oe_en;
  logic        start_a, start_b;
  logic [7:0]  data_a;
  logic [31:0] data_b;
  logic        busy_a, done_a, sr_clk_a, sr_data_a, sr_strobe_a, sr_oe_a;
  logic        busy_b, done_b, sr_clk_b, sr_data_b, sr_strobe_b, sr_oe_b;

  int checks = 0;
  int errors = 0;

  // Per-cycle trace of the 8-bit instance: {busy, done, sr_clk, sr_data, sr_strobe, sr_oe}
  logic [5:0]  out_tr [0:127];
  logic [63:0] m_bits;
  int          m_nrise, m_nstb, m_ndone, m_done1, m_done2, m_dviol;

  always #5 clk = ~clk;

  sr_4094_ctrl #(.WIDTH(8), .DIV(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .data(data_a), .oe_en(oe_en),
    .busy(busy_a), .done(done_a), .sr_clk(sr_clk_a), .sr_data(sr_data_a),
    .sr_strobe(sr_strobe_a), .sr_oe(sr_oe_a)
  );

  sr_4094_ctrl #(.WIDTH(32), .DIV(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .data(data_b), .oe_en(oe_en),
    .busy(busy_b), .done(done_b), .sr_clk(sr_clk_b), .sr_data(sr_data_b),
    .sr_strobe(sr_strobe_b), .sr_oe(sr_oe_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the current cycle. Each cycle: sample outputs, then drive that cycle's inputs.
  task automatic run_mon(input int ncyc, input logic st0, input logic [7:0] d0,
                         input int inj1, input logic [7:0] d1,
                         input int inj2, input logic [7:0] d2,
                         input int rst_at, input int oe_off_at);
    logic prev_clk, prev_dat;
    m_bits = '0; m_nrise = 0; m_nstb = 0; m_ndone = 0;
    m_done1 = -1; m_done2 = -1; m_dviol = 0;
    prev_clk = 1'b0; prev_dat = 1'b0;
    for (int k = 0; k <= ncyc; k++) begin
      if (k > 0) step();
      out_tr[k] = {busy_a, done_a, sr_clk_a, sr_data_a, sr_strobe_a, sr_oe_a};
      if (sr_clk_a && !prev_clk) begin
        m_bits = {m_bits[62:0], sr_data_a};
        m_nrise++;
      end
      if (k > 0 && sr_clk_a && prev_clk && (sr_data_a != prev_dat)) m_dviol++;
      if (sr_strobe_a) m_nstb++;
      if (done_a) begin
        m_ndone++;
        if (m_done1 < 0) m_done1 = k;
        else if (m_done2 < 0) m_done2 = k;
      end
      prev_clk = sr_clk_a;
      prev_dat = sr_data_a;
      // drive inputs for cycle k
      start_a = 1'b0;
      data_a  = 8'hEE;
      if (k == 0)    begin start_a = st0;  data_a = d0; end
      if (k == inj1) begin start_a = 1'b1; data_a = d1; end
      if (k == inj2) begin start_a = 1'b1; data_a = d2; end
      reset = (k == rst_at);
      oe_en = !(oe_off_at >= 0 && k >= oe_off_at);
    end
    start_a = 1'b0;
    reset   = 1'b0;
  endtask

  initial begin
    int oe_hi, nontog, rises_b, done_b_cyc, strb_b;
    logic [31:0] bits_b;
    logic prev_b;

    reset = 1'b1; oe_en = 1'b1;
    start_a = 1'b0; data_a = 8'h00;
    start_b = 1'b0; data_b = 32'h0;
    repeat (3) step();
    reset = 1'b0;

    // 1. after reset with oe_en held high, nothing is driven
    run_mon(10, 1'b0, 8'h00, -1, 8'h00, -1, 8'h00, -1, -1);
    oe_hi = 0;
    for (int k = 0; k <= 10; k++) oe_hi += int'(out_tr[k][0]);
    chk("t1_oe_never_high", 64'(oe_hi), 64'd0);
    chk("t1_outputs_zero", 64'(out_tr[10]), 64'd0);

    // 2. single transfer of A5
    run_mon(40, 1'b1, 8'hA5, -1, 8'h00, -1, 8'h00, -1, -1);
    chk("t2_bits", m_bits[7:0], 64'hA5);
    chk("t2_nrise", 64'(m_nrise), 64'd8);
    chk("t2_strobe_cycles", 64'(m_nstb), 64'd2);
    chk("t2_done_count", 64'(m_ndone), 64'd1);
    chk("t2_done_cycle", 64'(m_done1), 64'd35);
    chk("t2_busy_c1", 64'(out_tr[1][5]), 64'd1);
    chk("t2_busy_c34", 64'(out_tr[34][5]), 64'd1);
    chk("t2_busy_done", 64'(out_tr[35][5]), 64'd0);
    chk("t2_oe_at_done", 64'(out_tr[35][0]), 64'd0);
    chk("t2_oe_after_done", 64'(out_tr[36][0]), 64'd1);
    chk("t2_data_stable_hi", 64'(m_dviol), 64'd0);

    // 3. two starts while busy: only the latest queued word follows, back to back
    run_mon(80, 1'b1, 8'h3C, 5, 8'hFF, 10, 8'h0F, -1, -1);
    chk("t3_bits", m_bits[15:0], 64'h3C0F);
    chk("t3_nrise", 64'(m_nrise), 64'd16);
    chk("t3_done_count", 64'(m_ndone), 64'd2);
    chk("t3_done1", 64'(m_done1), 64'd35);
    chk("t3_done2", 64'(m_done2), 64'd70);
    chk("t3_busy_relaunch", 64'(out_tr[36][5]), 64'd1);

    // 4. reset during the 4th bit (its high phase is cycles 15-16)
    run_mon(60, 1'b1, 8'hA5, -1, 8'h00, -1, 8'h00, 15, -1);
    chk("t4_oe_before_rst", 64'(out_tr[15][0]), 64'd1);
    chk("t4_rise_before_rst", 64'(out_tr[15][3]), 64'd1);
    chk("t4_outputs_zero", 64'(out_tr[16]), 64'd0);
    chk("t4_no_done", 64'(m_ndone), 64'd0);
    chk("t4_no_strobe", 64'(m_nstb), 64'd0);
    oe_hi = 0;
    for (int k = 16; k <= 60; k++) oe_hi += int'(out_tr[k][0]);
    chk("t4_oe_stays_low", 64'(oe_hi), 64'd0);

    // reload after reset: OE comes back only after the full load
    run_mon(40, 1'b1, 8'h81, -1, 8'h00, -1, 8'h00, -1, -1);
    chk("t4b_bits", m_bits[7:0], 64'h81);
    chk("t4b_oe_at_done", 64'(out_tr[35][0]), 64'd0);
    chk("t4b_oe_after", 64'(out_tr[36][0]), 64'd1);

    // 5. drop oe_en mid-transfer
    run_mon(40, 1'b1, 8'h5A, -1, 8'h00, -1, 8'h00, -1, 10);
    chk("t5_oe_before", 64'(out_tr[10][0]), 64'd1);
    chk("t5_oe_dropped", 64'(out_tr[11][0]), 64'd0);
    chk("t5_bits", m_bits[7:0], 64'h5A);
    chk("t5_done_cycle", 64'(m_done1), 64'd35);
    chk("t5_oe_stays_off", 64'(out_tr[37][0]), 64'd0);
    oe_en = 1'b1;

    // 6. WIDTH=32, DIV=1
    start_b = 1'b1; data_b = 32'h8000_0001;
    bits_b = '0; rises_b = 0; nontog = 0; done_b_cyc = -1; strb_b = 0;
    prev_b = sr_clk_b;
    for (int k = 1; k <= 80; k++) begin
      step();
      start_b = 1'b0;
      data_b  = 32'hDEAD_BEEF;
      if (sr_clk_b && !prev_b) begin
        bits_b = {bits_b[30:0], sr_data_b};
        rises_b++;
      end
      if (k >= 2 && k <= 64 && sr_clk_b == prev_b) nontog++;
      if (sr_strobe_b) strb_b++;
      if (done_b && done_b_cyc < 0) done_b_cyc = k;
      prev_b = sr_clk_b;
    end
    chk("t6_nrise", 64'(rises_b), 64'd32);
    chk("t6_toggle_every_cycle", 64'(nontog), 64'd0);
    chk("t6_first_bit", 64'(bits_b[31]), 64'd1);
    chk("t6_last_bit", 64'(bits_b[0]), 64'd1);
    chk("t6_bits", 64'(bits_b), 64'h8000_0001);
    chk("t6_strobe_cycles", 64'(strb_b), 64'd1);
    chk("t6_done_cycle", 64'(done_b_cyc), 64'd66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
